// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a 256x64 byte-masked single-port SRAM macro:
// zero-fills the array after reset, then maps a valid/ready request channel onto port cycles.
module sram_port_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              rd_inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        buf_cnt;
    logic [1:0]        occ;
    logic              push, pop, credit, rd_fire;

    // A read slot is free if, after this cycle's pop, fewer than two results are owed.
    assign occ        = buf_cnt + {1'b0, rd_inflight};
    assign resp_valid = (buf_cnt != 2'd0);
    assign pop        = resp_valid && resp_ready;
    assign push       = rd_inflight;
    assign credit     = (occ - {1'b0, pop}) < 2'd2;
    assign resp_rdata = buf_mem[rd_ptr];
    assign init_done  = (state == RUN);
    assign rd_fire    = (state == RUN) && sram_en && !sram_wmode;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = req_write;
        sram_addr  = req_addr;
        sram_wmask = req_wmask;
        sram_wdata = req_wdata;
        case (state)
            INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = init_cnt;
                sram_wmask = '1;
                sram_wdata = '0;
                if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
            end
            RUN: begin
                // Writes produce no response, so backpressure never holds them off.
                req_ready = req_write || credit;
                sram_en   = req_valid && req_ready;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            init_cnt    <= '0;
            rd_inflight <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_cnt     <= 2'd0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= rd_fire;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Macro rdata follows later writes to the held address, so it is captured
    // exactly one cycle after the read and never forwarded combinationally.
    always_ff @(posedge clock) begin
        if (push) buf_mem[wr_ptr] <= sram_rdata;
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural SRAM macro, a memory/response-queue reference
// model, directed scenarios and a randomized traffic phase.
module tb_sram_port_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr, req_wmask;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        init_done;
    logic        sram_en, sram_wmode;
    logic [7:0]  sram_addr, sram_wmask;
    logic [63:0] sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;

    sram_port_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural macro: registered read, byte-masked write.
    logic [63:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        sram_rdata = {$urandom, $urandom};
    end
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int b = 0; b < 8; b++)
                    if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Reference model: array contents plus the in-order list of owed read results,
    // each visible from two cycles after its acceptance.
    typedef struct {
        logic [63:0] data;
        int          avail;
    } resp_t;

    logic [63:0] ref_mem [256];
    resp_t       q[$];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the clock low; returns at the next negedge.
    task automatic step(input logic v, input logic w, input logic [7:0] a, input logic [7:0] m,
                        input logic [63:0] d, input logic rr, output logic fired);
        logic head_ok, exp_pop, exp_rdy;
        req_valid = v; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
        resp_ready = rr;
        #1;
        head_ok = (q.size() > 0) && (q[0].avail <= cyc);
        exp_pop = head_ok && rr;
        exp_rdy = w || ((q.size() - (exp_pop ? 1 : 0)) < 2);
        chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, head_ok});
        if (head_ok) chk("resp_rdata", resp_rdata, q[0].data);
        fired = v && exp_rdy;
        chk("sram_en", {63'd0, sram_en}, {63'd0, fired});
        if (fired) begin
            chk("sram_wmode", {63'd0, sram_wmode}, {63'd0, w});
            chk("sram_addr", {56'd0, sram_addr}, {56'd0, a});
            if (w) begin
                chk("sram_wmask", {56'd0, sram_wmask}, {56'd0, m});
                chk("sram_wdata", sram_wdata, d);
            end
        end
        @(posedge clock);
        if (exp_pop) void'(q.pop_front());
        if (fired) begin
            if (w) begin
                for (int b = 0; b < 8; b++)
                    if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                q.push_back('{data: ref_mem[a], avail: cyc + 2});
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    // Runs n fill cycles checking the port; a complete fill also checks init_done.
    task automatic init_fill(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b1; req_write = 1'($urandom_range(0, 1));
            req_addr = 8'($urandom); resp_ready = 1'b1;
            #1;
            chk("init_en", {63'd0, sram_en}, 64'd1);
            chk("init_wmode", {63'd0, sram_wmode}, 64'd1);
            chk("init_addr", {56'd0, sram_addr}, 64'(i));
            chk("init_wmask", {56'd0, sram_wmask}, 64'hFF);
            chk("init_wdata", sram_wdata, 64'd0);
            chk("init_ready", {63'd0, req_ready}, 64'd0);
            chk("init_done_low", {63'd0, init_done}, 64'd0);
            chk("init_resp_valid", {63'd0, resp_valid}, 64'd0);
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        if (n == 256) begin
            req_valid = 1'b0;
            #1;
            chk("init_done_high", {63'd0, init_done}, 64'd1);
            for (int i = 0; i < 256; i++) ref_mem[i] = 64'd0;
        end
    endtask

    task automatic drain();
        logic f;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h0, 8'h0, 64'h0, 1'b1, f);
    endtask

    initial begin
        logic f;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wmask = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        init_fill(256);

        // Zero-filled word comes back at exactly two cycles.
        step(1'b1, 1'b0, 8'h7F, 8'h00, 64'h0, 1'b0, f);
        chk("rd7f_accept", {63'd0, f}, 64'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, f);
        step(1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, f);
        #1;
        chk("rd7f_valid", {63'd0, resp_valid}, 64'd1);
        chk("rd7f_data", resp_rdata, 64'd0);
        drain();

        // Byte-masked overwrite, then read-after-write next cycle.
        step(1'b1, 1'b1, 8'h10, 8'hFF, 64'h1122334455667788, 1'b0, f);
        step(1'b1, 1'b1, 8'h10, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, f);
        step(1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 1'b0, f);
        step(1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, f);
        step(1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, f);
        #1;
        chk("masked_data", resp_rdata, 64'h11223344FFFFFFFF);
        drain();

        // Backpressure: two reads fill the credit, writes still pass.
        step(1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 1'b0, f);
        chk("stall_rd1", {63'd0, f}, 64'd1);
        step(1'b1, 1'b0, 8'h7F, 8'h00, 64'h0, 1'b0, f);
        chk("stall_rd2", {63'd0, f}, 64'd1);
        step(1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 1'b0, f);
        chk("stall_rd3", {63'd0, f}, 64'd0);
        step(1'b1, 1'b1, 8'h20, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, f);
        chk("stall_wr", {63'd0, f}, 64'd1);
        step(1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 1'b0, f);
        chk("stall_rd3_hold", {63'd0, f}, 64'd0);
        step(1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 1'b1, f);
        chk("rd3_on_pop", {63'd0, f}, 64'd1);
        drain();

        // Sustained back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + 8'(i * 8)), 8'h00, 64'h0, 1'b1, f);
            chk("b2b_accept", {63'd0, f}, 64'd1);
        end
        drain();

        // Randomized traffic on a small address window to force collisions.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 8'(8'h20 + $urandom_range(0, 15)), 8'($urandom), {$urandom, $urandom},
                 1'($urandom_range(0, 3) != 0), f);
        drain();

        // Reset in the middle of the fill restarts it from address 0.
        reset_n = 1'b0;
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        init_fill(100);
        #1;
        chk("mid_init_addr", {56'd0, sram_addr}, 64'd100);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", {56'd0, sram_addr}, 64'd0);
        chk("mid_rst_done", {63'd0, init_done}, 64'd0);
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        init_fill(256);
        drain();

        // Reset with two responses buffered drops them immediately.
        for (int i = 0; i < 2; i++) begin
            ref_mem[8'h30 + i] = ref_mem[8'h30 + i];
            step(1'b1, 1'b1, 8'(8'h30 + i), 8'hFF, {$urandom, $urandom}, 1'b0, f);
        end
        step(1'b1, 1'b0, 8'h30, 8'h00, 64'h0, 1'b0, f);
        step(1'b1, 1'b0, 8'h31, 8'h00, 64'h0, 1'b0, f);
        step(1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, f);
        step(1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, f);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("async_rst_ready", {63'd0, req_ready}, 64'd0);
        q.delete();
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        init_fill(256);
        step(1'b1, 1'b0, 8'h30, 8'h00, 64'h0, 1'b1, f);
        step(1'b1, 1'b0, 8'h31, 8'h00, 64'h0, 1'b1, f);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Initiator-side controller for the single-port 256x64 byte-masked SRAM macro (one-cycle registered read latency).
- Zero-fills the whole array after reset. Then converts a valid/ready request channel into SRAM port cycles and returns read data on a backpressurable response channel through a 2-entry buffer.
- Sits between pipeline logic and the SRAM macro; the sram_* outputs connect directly to the macro's RW0_* pins.

Parameters:
- DEPTH, 256, number of SRAM words.
- ADDR_W, 8, address width; log2(DEPTH).
- DATA_W, 64, data width.
- MASK_W, 8, byte-mask width; DATA_W/8.

Ports:
- clock  in  1  rising-edge clock; also drives the SRAM RW0_clk.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wmask  in  MASK_W  byte enables; ignored for reads.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  read data.
- init_done  out  1  zero-fill complete.
- sram_en  out  1  to RW0_en.
- sram_wmode  out  1  to RW0_wmode.
- sram_addr  out  ADDR_W  to RW0_addr.
- sram_wmask  out  MASK_W  to RW0_wmask.
- sram_wdata  out  DATA_W  to RW0_wdata.
- sram_rdata  in  DATA_W  from RW0_rdata.

Behaviour:
- Reset (async assert, sync release):
  - state=INIT, init_cnt=0, init_done=0, rd_inflight=0, response buffer empty.
  - resp_valid=0, req_ready=0.
- State INIT, one word per cycle:
  - Outputs: sram_en=1, sram_wmode=1, sram_addr=init_cnt, sram_wmask=all ones, sram_wdata=0.
  - init_cnt increments each cycle.
  - On the cycle writing DEPTH-1, next state=RUN.
  - Total DEPTH cycles; init_done=1 from the first RUN cycle.
  - req_ready=0 throughout INIT.
- State RUN, port driving (combinational from the request when it fires):
  - sram_en = req_valid && req_ready.
  - sram_wmode = req_write.
  - sram_addr / sram_wmask / sram_wdata = req fields.
  - When no request fires: sram_en=0; other sram_* outputs are don't-care but held at the req values.
- Occupancy:
  - occ = buffer_count + rd_inflight.
  - Read credit = (occ - (resp_valid && resp_ready)) < 2.
- Ready rule:
  - req_ready = RUN && (req_write || read credit).
  - Writes are never blocked by response backpressure.
  - req_ready may depend on req_write.
- Read latency:
  - Read accepted at cycle T sets rd_inflight=1 for T+1.
  - At the end of T+1, sram_rdata is pushed into the buffer.
  - resp_valid rises at T+2 at the earliest. Fixed latency 2 when the buffer is empty.
  - Data is always captured at T+1 and never passed combinationally, because macro rdata tracks later writes to the held address.
- Response buffer:
  - 2-entry FIFO, in order.
  - Push and pop in the same cycle are allowed.
  - resp_valid = buffer non-empty; resp_rdata = head.
  - Overflow is impossible by the credit rule.
- Back-to-back reads: one per cycle sustained while resp_ready=1.
- Write: single cycle, no response. A read to the same address in the next cycle returns the new data.
- Reset mid-operation:
  - Inflight reads and buffered responses are discarded.
  - INIT restarts from address 0.

Test Plan:
- Reset release -> exactly 256 INIT cycles with sram_en=1, sram_wmode=1, addresses 0..255 in order; init_done=1 at cycle 256; req_ready=0 until then; then read addr 0x7F returns 0x0 at latency 2.
- Write addr 0x10 data 0x1122334455667788 mask 0xFF, then write 0xFFFFFFFFFFFFFFFF mask 0x0F, then read 0x10 -> 0x11223344FFFFFFFF.
- resp_ready=0, issue 3 reads -> first two accepted, third stalled (req_ready=0); a write issued meanwhile is accepted; raising resp_ready -> responses in order, third read accepted the same cycle as the first pop.
- 8 back-to-back reads with resp_ready=1 -> one accept per cycle, 8 responses on consecutive cycles, first at T+2.
- Assert reset_n=0 at INIT address 100 -> init_cnt=0, init_done=0; after release, full 256-cycle fill restarts.
- Assert reset_n=0 with 2 responses buffered -> resp_valid=0 immediately (async); no stale data after re-init.
